// File: rtl/regbank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_rr_arbiter
// Purpose  : Round-robin arbiter between two requesters (A, B). Each requester
//            issues single-register read/write transactions over a REQ/ACK
//            handshake. The transactions target a bank of four WIDTH-bit
//            enable-gated registers that this block owns exclusively.
//
// Ports    : CLK        - system clock, rising edge active
//            RESET      - asynchronous reset, active low
//            CLR        - bank clear request, only present with REGBANK_CLEAR_EN
//            REQ_A/B    - transaction request (level), held until ACK
//            WE_A/B     - 1 = write, 0 = read
//            ADDR_A/B   - target register index 0..3
//            WDATA_A/B  - write data
//            ACK_A/B    - one-cycle completion pulse to the served requester
//            RDATA      - read data, valid in the cycle ACK_A or ACK_B is high
//            BUSY       - high in any state other than IDLE
//            LAST_GNT   - 0 = A served last, 1 = B served last
//
// Config   : `define REGBANK_CLEAR_EN adds the CLR input and a one-cycle
//            CLEAR state that zeroes the whole bank.
//
// Revision : 1.0 - initial release
// ============================================================================
module regbank_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
`ifdef REGBANK_CLEAR_EN
    input  logic             CLR,
`endif
    input  logic             REQ_A,
    input  logic             WE_A,
    input  logic [1:0]       ADDR_A,
    input  logic [WIDTH-1:0] WDATA_A,
    output logic             ACK_A,
    input  logic             REQ_B,
    input  logic             WE_B,
    input  logic [1:0]       ADDR_B,
    input  logic [WIDTH-1:0] WDATA_B,
    output logic             ACK_B,
    output logic [WIDTH-1:0] RDATA,
    output logic             BUSY,
    output logic             LAST_GNT
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
`ifdef REGBANK_CLEAR_EN
        , ST_CLEAR  = 2'd3
`endif
    } state_t;

    localparam int NUM_REGS = 4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             state_q;
    logic               we_q;          // latched transaction type
    logic [1:0]         addr_q;        // latched register index
    logic [WIDTH-1:0]   wdata_q;       // latched write data
    logic               id_q;          // latched requester id (0 = A, 1 = B)
    logic [WIDTH-1:0]   rdata_q;
    logic               ack_a_q;
    logic               ack_b_q;
    logic               last_gnt_q;
    logic [WIDTH-1:0]   bank_q [NUM_REGS];

    // ------------------------------------------------------------------------
    // Arbitration and field selection (only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic               sel_b_d;       // 1 = B wins this IDLE cycle
    logic               req_any_d;
    logic               we_d;
    logic [1:0]         addr_d;
    logic [WIDTH-1:0]   wdata_d;

    always_comb begin
        req_any_d = REQ_A | REQ_B;
        sel_b_d   = 1'b0;
        if (REQ_A && REQ_B) begin
            // Under contention the requester that was not served last wins.
            sel_b_d = ~last_gnt_q;
        end else begin
            sel_b_d = REQ_B;
        end
        we_d    = sel_b_d ? WE_B    : WE_A;
        addr_d  = sel_b_d ? ADDR_B  : ADDR_A;
        wdata_d = sel_b_d ? WDATA_B : WDATA_A;
    end

    // ------------------------------------------------------------------------
    // Bank load enables: at most one bit set, only during a latched write.
    // ------------------------------------------------------------------------
    logic [NUM_REGS-1:0] bank_en_d;
    logic                bank_clr_d;

    always_comb begin
        bank_en_d = '0;
        if ((state_q == ST_ACCESS) && we_q) begin
            bank_en_d[addr_q] = 1'b1;
        end
    end

`ifdef REGBANK_CLEAR_EN
    assign bank_clr_d = (state_q == ST_CLEAR);
`else
    assign bank_clr_d = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Register bank. The asynchronous reset also covers a write that is in
    // flight in ACCESS when reset asserts, so such a write never lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bank_clr_d) begin
                    bank_q[i] <= '0;
                end else if (bank_en_d[i]) begin
                    bank_q[i] <= wdata_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // Timeline: REQ sampled in IDLE (cycle N) -> ACCESS (N+1) -> RESP with
    // ACK high (N+2) -> IDLE (N+3).
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= 1'b0;
            rdata_q    <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            // B counts as served last so that A wins the first contention.
            last_gnt_q <= 1'b1;
        end else begin
            // ACK is a single-cycle pulse; it is only set on ACCESS exit.
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
`ifdef REGBANK_CLEAR_EN
                    // Clear has priority over both requesters.
                    if (CLR) begin
                        state_q <= ST_CLEAR;
                    end else if (req_any_d) begin
`else
                    if (req_any_d) begin
`endif
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        id_q    <= sel_b_d;
                        state_q <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // Write data lands in the bank on this same edge via
                    // bank_en_d; a read captures the current contents.
                    if (!we_q) begin
                        rdata_q <= bank_q[addr_q];
                    end
                    last_gnt_q <= id_q;
                    ack_a_q    <= ~id_q;
                    ack_b_q    <= id_q;
                    state_q    <= ST_RESP;
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

`ifdef REGBANK_CLEAR_EN
                ST_CLEAR: begin
                    // Bank zeroing happens through bank_clr_d; no ACK and
                    // LAST_GNT is left untouched.
                    state_q <= ST_IDLE;
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ACK_A    = ack_a_q;
    assign ACK_B    = ack_b_q;
    assign RDATA    = rdata_q;
    assign LAST_GNT = last_gnt_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
